// File: rtl/im_port_arbiter.sv
// im_port_arbiter: shares the instruction ROM read port between the fetch
// stage (F, priority) and a debug reader (D, bounded wait). Byte addresses
// are rebased by TEXT_BASE and turned into word indices; read data is
// registered, so responses arrive one cycle after the grant.
// Optional build macro IM_ADDR_CHECK_EN adds f_err/d_err range/alignment
// flags and returns zero data for erroring reads.
module im_port_arbiter #(
  parameter logic [31:0] TEXT_BASE    = 32'h0000_3000,
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  input  logic                  d_req,
  input  logic [31:0]           d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic [DEPTH_LOG2-1:0] im_idx,
  input  logic [31:0]           im_rdata,
  output logic [2:0]            wait_cnt
`ifdef IM_ADDR_CHECK_EN
  ,
  output logic                  f_err,
  output logic                  d_err
`endif
);

  typedef enum logic {S_FPRI, S_DSLOT} state_t;

  state_t                state_q, state_d;
  logic [2:0]            wait_q, wait_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  f_rvalid_q, d_rvalid_q;
  logic [31:0]           f_rdata_q, d_rdata_q;
  logic                  f_gnt_c, d_gnt_c, any_gnt, d_waiting;
  logic [31:0]           gnt_addr, offset, rom_word;
  logic [DEPTH_LOG2-1:0] idx_new;
`ifdef IM_ADDR_CHECK_EN
  logic                  f_err_q, d_err_q, addr_err;
`endif

  // Grant selection: forced debug slot first, then fetch, then debug.
  always_comb begin
    f_gnt_c = 1'b0;
    d_gnt_c = 1'b0;
    if (reset) begin
      if (state_q == S_DSLOT && d_req) d_gnt_c = 1'b1;
      else if (f_req)                  f_gnt_c = 1'b1;
      else if (d_req)                  d_gnt_c = 1'b1;
    end
  end

  assign any_gnt   = f_gnt_c | d_gnt_c;
  assign d_waiting = reset & d_req & ~d_gnt_c;

  // Starvation counter and next arbitration state.
  always_comb begin
    wait_d  = '0;
    state_d = S_FPRI;
    if (d_waiting) begin
      wait_d = (wait_q == 3'd7) ? 3'd7 : wait_q + 3'd1;
      if (wait_q == 3'(STARVE_LIMIT - 1)) state_d = S_DSLOT;
    end
  end

  // Address translation of the granted requester and data selection.
  always_comb begin
    gnt_addr = f_gnt_c ? f_addr : d_addr;
    offset   = gnt_addr - TEXT_BASE;
    idx_new  = DEPTH_LOG2'(offset >> 2);
    rom_word = im_rdata;
`ifdef IM_ADDR_CHECK_EN
    addr_err = (gnt_addr[1:0] != 2'b00) || (gnt_addr < TEXT_BASE) ||
               ({1'b0, gnt_addr} >= ({1'b0, TEXT_BASE} + (33'd1 << (DEPTH_LOG2 + 2))));
    if (addr_err) rom_word = '0;
`endif
  end

  // Index holds its last granted value while the port is idle.
  assign im_idx = any_gnt ? idx_new : idx_q;

  // All state: FSM, counter, index hold, response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_FPRI;
      wait_q     <= '0;
      idx_q      <= '0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef IM_ADDR_CHECK_EN
      f_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      f_rvalid_q <= f_gnt_c;
      d_rvalid_q <= d_gnt_c;
      if (any_gnt) idx_q <= idx_new;
      if (f_gnt_c) f_rdata_q <= rom_word;
      if (d_gnt_c) d_rdata_q <= rom_word;
`ifdef IM_ADDR_CHECK_EN
      f_err_q    <= f_gnt_c & addr_err;
      d_err_q    <= d_gnt_c & addr_err;
`endif
    end
  end

  assign f_gnt    = f_gnt_c;
  assign d_gnt    = d_gnt_c;
  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign wait_cnt = wait_q;
`ifdef IM_ADDR_CHECK_EN
  assign f_err    = f_err_q;
  assign d_err    = d_err_q;
`endif

endmodule
